fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control FSM that fetches 24-bit instructions from the 8-bit program memory as three byte reads. It assembles each instruction and loads it into the instruction register with a one-cycle enable pulse. It then hands the instruction to the execute stage and waits for completion before fetching the next one. It owns the program counter and sits between program memory, the instruction register and the execute/decode logic of the 8-bit CPU.

## Interface
- RESET_PC, 8'h00, PC value after reset
- TIMEOUT_CYCLES, 15, max wait for mem_ack per byte (used only with FETCH_TIMEOUT_EN)

- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- run  input  1  start fetching; sampled only in IDLE
- mem_addr  output  8  byte address; equals pc
- mem_req  output  1  read request, held until acknowledged
- mem_ack  input  1  read done; mem_rdata valid in the same cycle
- mem_rdata  input  8  read byte
- ir_data  output  24  assembled instruction, drives instruction_register.in
- ir_enable  output  1  one-cycle load strobe to instruction_register.enable
- exec_start  output  1  one-cycle pulse: instruction register holds a new instruction
- exec_done  input  1  execute stage finished current instruction
- halt_req  input  1  current instruction is HALT; sampled with exec_done
- branch_taken  input  1  redirect PC; sampled with exec_done
- branch_target  input  8  new PC when branch_taken
- pc  output  8  current program counter
- busy  output  1  high in any state except IDLE and HALT
- halted  output  1  high in HALT
- fault  output  1  fetch timeout (FETCH_TIMEOUT_EN only, else constant 0)

## Operation
- States: IDLE, FETCH0, FETCH1, FETCH2, LOAD, EXEC, HALT (plus FAULT with the macro).
- IDLE: when run=1, go to FETCH0.
- FETCHn: mem_req=1 and mem_addr=pc. On a clock edge where mem_ack=1:
  - capture mem_rdata into the byte lane: FETCH0→ir_data[23:16] (opcode), FETCH1→[15:8], FETCH2→[7:0];
  - pc increments by 1, wrapping 8'hFF→8'h00;
  - advance to the next state.
- LOAD: ir_enable=1 for exactly this cycle. ir_data is stable and unchanged until the next FETCH0 capture. Next state is EXEC.
- EXEC: exec_start=1 in the first EXEC cycle only. Stay in EXEC until exec_done=1. exec_done is accepted in the same cycle as exec_start. On exec_done:
  - halt_req=1 → HALT; halt_req has priority over branch_taken;
  - else branch_taken=1 → pc ← branch_target, then FETCH0;
  - else → FETCH0 (pc is already at the next instruction).
- HALT: absorbing state; left only through reset.
- Ignored inputs:
  - mem_ack while mem_req=0;
  - run outside IDLE (deasserting run mid-instruction does not stop the sequence);
  - branch_taken and halt_req without exec_done.
- Reset (rst_n=0 at any edge, including mid-fetch with mem_req high): state IDLE, pc=RESET_PC, ir_data=0. All outputs 0 except mem_addr=RESET_PC. The outstanding request is abandoned, and mem_req is low in the cycle after the reset edge.

## Timing
- All outputs are registered or decoded from the state register only; no combinational paths from input to output.
- With mem_ack high in the first request cycle of each byte:
  - FETCH0 entry to ir_enable: 3 cycles (ir_enable in the 4th cycle);
  - exec_start one cycle after ir_enable.
- Minimum instruction period: 5 cycles (3 fetch, 1 load, 1 exec with immediate exec_done).
- Each additional mem_ack wait cycle adds one cycle. mem_addr and mem_req are stable while waiting.
- pc update from branch_target is visible the cycle after exec_done, coincident with FETCH0 entry.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - a per-byte wait counter (width clog2(TIMEOUT_CYCLES+1)) resets on entry to each FETCHn;
  - when TIMEOUT_CYCLES cycles pass with mem_req=1 and no mem_ack, go to FAULT: mem_req=0, fault=1, busy=0;
  - FAULT is left only through reset.
- FETCH_TIMEOUT_EN undefined: no counter and no FAULT state; FETCHn waits indefinitely; fault is tied to 0.

## Structure
- Package cpu8_pkg holds:
  - the fetch state enum;
  - INSTR_W=24, BYTE_W=8, ADDR_W=8, BYTES_PER_INSTR=3;
  - opcode byte lane position constants.
- Sub-module program_counter: 8-bit register with sync active-low reset to RESET_PC, load (priority) and increment inputs, wrap-around. The FSM and byte-assembly register stay in fetch_sequencer.

## Test plan
- Reset, run=1, memory bytes 0x12,0x34,0x56 at 0..2 with immediate ack → ir_data=24'h123456 with a single ir_enable pulse in cycle 4, exec_start in cycle 5, pc=3.
- Ack delayed 2 cycles on byte 1 → mem_addr=1 and mem_req held 3 cycles; ir_enable 2 cycles later than the baseline; ir_data unchanged across the delay.
- exec_done with branch_taken=1, branch_target=8'hFE → next mem_addr=FE; fetch reads FE, FF, 00 (wrap) and pc=1 afterwards.
- exec_done with halt_req=1 and branch_taken=1 → HALT, halted=1, busy=0, no further mem_req despite run=1.
- rst_n=0 during FETCH1 with mem_req high → next cycle IDLE, mem_req=0, pc=RESET_PC, ir_data=0; re-run refetches from 0.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=15, mem_ack never asserted → fault=1 after 15 request cycles, mem_req=0; without the macro, mem_req stays high.

Source files
------------

// File: rtl/cpu8_pkg.sv
// cpu8 shared types and constants.
// Fetch FSM state set grows a FAULT state under FETCH_TIMEOUT_EN.
package cpu8_pkg;

  localparam int INSTR_W         = 24;
  localparam int BYTE_W          = 8;
  localparam int ADDR_W          = 8;
  localparam int BYTES_PER_INSTR = 3;

  localparam int OPC_LSB = 16;
  localparam int B1_LSB  = 8;
  localparam int B2_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_LOAD,
    S_EXEC,
    S_HALT
`ifdef FETCH_TIMEOUT_EN
    , S_FAULT
`endif
  } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter: sync active-low reset, load beats increment.
// Increment wraps 8'hFF -> 8'h00.
module program_counter
  import cpu8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  // pc register: load has priority over increment
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      pc_q <= RESET_PC;
    else if (load_i)
      pc_q <= load_val_i;
    else if (inc_i)
      pc_q <= pc_q + ADDR_W'(1);
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM: three byte reads -> IR load -> execute handshake.
// FETCH_TIMEOUT_EN adds a per-byte ack timeout and a FAULT state.
module fetch_sequencer
  import cpu8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC       = 8'h00,
  parameter int                TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_req,
  input  logic               mem_ack,
  input  logic [BYTE_W-1:0]  mem_rdata,
  output logic [INSTR_W-1:0] ir_data,
  output logic               ir_enable,
  output logic               exec_start,
  input  logic               exec_done,
  input  logic               halt_req,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               fault
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               start_q;
  logic               pc_inc, pc_ld;

`ifdef FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_q, wait_d;
`endif

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (pc_ld),
    .load_val_i (branch_target),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  // state, assembled instruction and exec_start pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      start_q <= (state_q == S_LOAD);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // per-byte ack wait counter
  always_ff @(posedge clk) begin
    if (!rst_n)
      wait_q <= '0;
    else
      wait_q <= wait_d;
  end
`endif

  // next state, byte capture and pc control
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_d  = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (run)
          state_d = S_FETCH0;
      end
      S_FETCH0, S_FETCH1, S_FETCH2: begin
        if (mem_ack) begin
          pc_inc = 1'b1;
          if (state_q == S_FETCH0) begin
            ir_d[OPC_LSB +: BYTE_W] = mem_rdata;
            state_d = S_FETCH1;
          end else if (state_q == S_FETCH1) begin
            ir_d[B1_LSB +: BYTE_W] = mem_rdata;
            state_d = S_FETCH2;
          end else begin
            ir_d[B2_LSB +: BYTE_W] = mem_rdata;
            state_d = S_LOAD;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_q == TO_W'(TIMEOUT_CYCLES - 1))
          state_d = S_FAULT;
        else
          wait_d = wait_q + TO_W'(1);
`endif
      end
      S_LOAD: state_d = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
            pc_ld   = branch_taken;
            state_d = S_FETCH0;
          end
        end
      end
      S_HALT: state_d = S_HALT;
`ifdef FETCH_TIMEOUT_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr   = pc;
  assign mem_req    = (state_q == S_FETCH0) ||
                      (state_q == S_FETCH1) ||
                      (state_q == S_FETCH2);
  assign ir_data    = ir_q;
  assign ir_enable  = (state_q == S_LOAD);
  assign exec_start = start_q;
  assign busy       = mem_req ||
                      (state_q == S_LOAD) ||
                      (state_q == S_EXEC);
  assign halted     = (state_q == S_HALT);
`ifdef FETCH_TIMEOUT_EN
  assign fault      = (state_q == S_FAULT);
`else
  assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte memory model plus IR scoreboard.
// Timeout section adapts to FETCH_TIMEOUT_EN.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [23:0] ir_data;
  logic        ir_enable;
  logic        exec_start;
  logic        exec_done;
  logic        halt_req;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        fault;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [256];
  int          dly [256];
  bit          no_ack;
  int          wait_cnt;
  logic [23:0] exp_q [$];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC       (8'h00),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ir_data       (ir_data),
    .ir_enable     (ir_enable),
    .exec_start    (exec_start),
    .exec_done     (exec_done),
    .halt_req      (halt_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // memory: ack after dly[addr] wait cycles, junk data otherwise
  always @(negedge clk) begin
    if (mem_req === 1'b1 && !no_ack) begin
      if (wait_cnt >= dly[mem_addr]) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wait_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        wait_cnt++;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'hEE;
      wait_cnt  = 0;
    end
  end

  // scoreboard: each IR load strobe pops one expected instruction
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ir_enable === 1'b1) begin
      if (exp_q.size() == 0)
        chk("sb_empty", 32'd1, 32'd0);
      else
        chk("ir_data", {8'h0, ir_data}, {8'h0, exp_q.pop_front()});
    end
  end

  task automatic do_instr(input string tag, input int exp_lat,
                          input logic [7:0] a0, input int exp_hold,
                          input logic [7:0] exp_pc, input bit br,
                          input logic [7:0] tgt, input bit hlt);
    int lat;
    int hold;
    lat  = 0;
    hold = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      exec_done    = 1'b0;
      branch_taken = 1'b0;
      halt_req     = 1'b0;
      if (k == 1) begin
        chk({tag, "_a0"}, {24'h0, mem_addr}, {24'h0, a0});
        chk({tag, "_req0"}, {31'h0, mem_req}, 32'd1);
      end
      if (mem_req && mem_addr == a0 + 8'd1)
        hold++;
      if (ir_enable) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_hold"}, hold, exp_hold);
    tick();
    chk({tag, "_xstart"}, {31'h0, exec_start}, 32'd1);
    chk({tag, "_irenpulse"}, {31'h0, ir_enable}, 32'd0);
    chk({tag, "_pc"}, {24'h0, pc}, {24'h0, exp_pc});
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    halt_req      = hlt;
  endtask

  initial begin
    int reqs;
    rst_n = 1'b0; run = 1'b0; no_ack = 1'b0; wait_cnt = 0;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    exec_done = 1'b0; halt_req = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i ^ 8'h5A);
      dly[i] = 0;
    end
    tick();
    tick();
    chk("rst_req", {31'h0, mem_req}, 32'd0);
    chk("rst_addr", {24'h0, mem_addr}, 32'd0);
    chk("rst_ir", {8'h0, ir_data}, 32'd0);
    chk("rst_flags", {28'h0, busy, halted, fault, ir_enable}, 32'd0);
    chk("rst_xs", {31'h0, exec_start}, 32'd0);

    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    mem[3] = 8'hAB; mem[4] = 8'hCD; mem[5] = 8'hEF;
    mem[8'hFE] = 8'h9A; mem[8'hFF] = 8'hBC;
    dly[4] = 2;
    exp_q.push_back(24'h123456);
    exp_q.push_back(24'hABCDEF);
    exp_q.push_back(24'h9ABC12);
    rst_n = 1'b1;
    run   = 1'b1;
    do_instr("base", 4, 8'h00, 1, 8'h03, 1'b0, 8'h00, 1'b0);
    run = 1'b0;
    do_instr("wait", 6, 8'h03, 3, 8'h06, 1'b1, 8'hFE, 1'b0);
    do_instr("wrap", 4, 8'hFE, 1, 8'h01, 1'b1, 8'h40, 1'b1);
    run = 1'b1;
    tick();
    exec_done = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
    chk("halt_h", {31'h0, halted}, 32'd1);
    chk("halt_busy", {31'h0, busy}, 32'd0);
    chk("halt_pc", {24'h0, pc}, 32'd1);
    reqs = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (mem_req) reqs++;
    end
    chk("halt_noreq", reqs, 0);
    chk("halt_stay", {31'h0, halted}, 32'd1);

    rst_n = 1'b0;
    tick();
    dly[1] = 5;
    rst_n = 1'b1;
    tick();
    tick();
    chk("mid_req", {31'h0, mem_req}, 32'd1);
    chk("mid_addr", {24'h0, mem_addr}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mrst_req", {31'h0, mem_req}, 32'd0);
    chk("mrst_pc", {24'h0, pc}, 32'd0);
    chk("mrst_ir", {8'h0, ir_data}, 32'd0);
    chk("mrst_busy", {31'h0, busy}, 32'd0);
    rst_n = 1'b1;
    run   = 1'b0;
    tick();
    chk("idle_req", {31'h0, mem_req}, 32'd0);
    dly[1] = 0;
    exp_q.push_back(24'h123456);
    run = 1'b1;
    do_instr("rerun", 4, 8'h00, 1, 8'h03, 1'b0, 8'h00, 1'b0);
    tick();
    exec_done = 1'b0;

    rst_n = 1'b0;
    run   = 1'b0;
    tick();
    rst_n  = 1'b1;
    no_ack = 1'b1;
    run    = 1'b1;
    reqs = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (mem_req) reqs++;
    end
`ifdef FETCH_TIMEOUT_EN
    chk("to_reqs", reqs, 15);
    chk("to_fault", {31'h0, fault}, 32'd1);
    chk("to_req", {31'h0, mem_req}, 32'd0);
    chk("to_busy", {31'h0, busy}, 32'd0);
`else
    chk("to_reqs", reqs, 20);
    chk("to_fault", {31'h0, fault}, 32'd0);
    chk("to_req", {31'h0, mem_req}, 32'd1);
`endif
    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
